// File: rtl/uart_wb_slave_if.sv
// Wishbone slave bus bundle for the UART register block.
// The master drives the request side and the slave drives the termination side.
interface uart_wb_slave_if;
   logic [31:0] adr_i;
   logic [31:0] dat_i;
   logic [31:0] dat_o;
   logic [3:0]  sel_i;
   logic        we_i;
   logic        cyc_i;
   logic        stb_i;
   logic        ack_o;
   logic        err_o;
   logic        rty_o;
   logic        stall_o;

   modport master (
      output adr_i, dat_i, sel_i, we_i, cyc_i, stb_i,
      input  dat_o, ack_o, err_o, rty_o, stall_o
   );

   modport slave (
      input  adr_i, dat_i, sel_i, we_i, cyc_i, stb_i,
      output dat_o, ack_o, err_o, rty_o, stall_o
   );
endinterface

// File: rtl/uart_wb_slave.sv
// Memory-mapped UART front end: RX/TX byte FIFOs behind a Wishbone slave,
// plus an autonomous start handshake toward the async transmitter.
module uart_wb_slave #(
   parameter int FIFO_DEPTH = 16
) (
   input  logic                  clk_bus,
   input  logic                  rst_bus,
   uart_wb_slave_if.slave        bus,
   input  logic [7:0]            rx_data,
   input  logic                  rx_ready,
   output logic [7:0]            tx_data,
   output logic                  tx_start,
   input  logic                  tx_busy
);

   localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [AW:0] CNT_FULL = (AW+1)'(FIFO_DEPTH);
   localparam logic [AW:0] CNT_ZERO = (AW+1)'(0);
   localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_GUARD = 2'd2
   } tx_state_t;

   tx_state_t       tx_state;
   tx_state_t       tx_state_next;

   logic [7:0]      rx_mem [FIFO_DEPTH];
   logic [7:0]      tx_mem [FIFO_DEPTH];
   logic [AW-1:0]   rx_wr_ptr;
   logic [AW-1:0]   rx_rd_ptr;
   logic [AW-1:0]   tx_wr_ptr;
   logic [AW-1:0]   tx_rd_ptr;
   logic [AW:0]     rx_count;
   logic [AW:0]     tx_count;
   logic            rx_overflow;

   logic            ack;
   logic            err;
   logic            rty;
   logic [31:0]     dat;
   logic [31:0]     rd_data;

   logic [1:0]      reg_sel;
   logic            accept;
   logic            is_data;
   logic            is_status;
   logic            is_unmapped;
   logic            rx_empty;
   logic            rx_full;
   logic            tx_empty;
   logic            tx_full;
   logic            tx_idle;
   logic            rx_push;
   logic            rx_pop;
   logic            tx_wr_req;
   logic            tx_push;
   logic            tx_pop;
   logic            tx_retry;
   logic            ovf_set;
   logic            ovf_clr;
   logic            unused_bits;

   assign reg_sel     = bus.adr_i[3:2];
   assign accept      = bus.cyc_i & bus.stb_i;
   assign is_data     = (reg_sel == 2'd0);
   assign is_status   = (reg_sel == 2'd1);
   assign is_unmapped = reg_sel[1];

   assign rx_empty    = (rx_count == CNT_ZERO);
   assign rx_full     = (rx_count == CNT_FULL);
   assign tx_empty    = (tx_count == CNT_ZERO);
   assign tx_full     = (tx_count == CNT_FULL);
   assign tx_idle     = tx_empty & (tx_state == TX_IDLE) & ~tx_busy;

   // A pop frees the slot a same-cycle push needs, so full-with-pop still pushes.
   assign rx_pop      = accept & ~bus.we_i & is_data & ~rx_empty;
   assign rx_push     = rx_ready & (~rx_full | rx_pop);
   assign ovf_set     = rx_ready & rx_full & ~rx_pop;
   assign ovf_clr     = accept & bus.we_i & is_status & bus.sel_i[0] & bus.dat_i[2];

   assign tx_wr_req   = accept & bus.we_i & is_data & bus.sel_i[0];
   assign tx_push     = tx_wr_req & (~tx_full | tx_pop);
   assign tx_retry    = tx_wr_req & tx_full & ~tx_pop;

   assign bus.ack_o   = ack;
   assign bus.err_o   = err;
   assign bus.rty_o   = rty;
   assign bus.dat_o   = dat;
   assign bus.stall_o = 1'b0;

   assign unused_bits = ^{bus.adr_i[31:4], bus.adr_i[1:0], bus.dat_i[31:8],
                          bus.sel_i[3:1]};

   // Transmit sequencer: pop when idle, then fixed START and GUARD cycles.
   always_comb begin
      tx_state_next = tx_state;
      tx_pop        = 1'b0;
      case (tx_state)
         TX_IDLE: begin
            if (!tx_empty && !tx_busy) begin
               tx_pop        = 1'b1;
               tx_state_next = TX_START;
            end else begin
               tx_state_next = TX_IDLE;
            end
         end
         TX_START: tx_state_next = TX_GUARD;
         TX_GUARD: tx_state_next = TX_IDLE;
         default:  tx_state_next = TX_IDLE;
      endcase
   end

   // Read-data selection for the register addressed by the current strobe.
   always_comb begin
      rd_data = 32'd0;
      if (bus.we_i) begin
         rd_data = 32'd0;
      end else begin
         case (reg_sel)
            2'd0: begin
               if (rx_empty) begin
                  rd_data = 32'd0;
               end else begin
                  rd_data = {24'd0, rx_mem[rx_rd_ptr]};
               end
            end
            2'd1:    rd_data = {28'd0, tx_idle, rx_overflow, ~tx_full, ~rx_empty};
            default: rd_data = 32'd0;
         endcase
      end
   end

   // Bus termination and read data, registered one cycle after acceptance.
   always_ff @(posedge clk_bus or posedge rst_bus) begin
      if (rst_bus) begin
         ack <= 1'b0;
         err <= 1'b0;
         rty <= 1'b0;
         dat <= 32'd0;
      end else begin
         ack <= accept & ~is_unmapped & ~tx_retry;
         err <= accept & is_unmapped;
         rty <= tx_retry;
         dat <= accept ? rd_data : 32'd0;
      end
   end

   // RX FIFO pointers, occupancy and sticky overflow flag (set beats clear).
   always_ff @(posedge clk_bus or posedge rst_bus) begin
      if (rst_bus) begin
         rx_wr_ptr   <= {AW{1'b0}};
         rx_rd_ptr   <= {AW{1'b0}};
         rx_count    <= CNT_ZERO;
         rx_overflow <= 1'b0;
      end else begin
         if (rx_push) rx_wr_ptr <= rx_wr_ptr + PTR_ONE;
         if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + PTR_ONE;
         case ({rx_push, rx_pop})
            2'b10:   rx_count <= rx_count + CNT_ONE;
            2'b01:   rx_count <= rx_count - CNT_ONE;
            default: rx_count <= rx_count;
         endcase
         if (ovf_set) begin
            rx_overflow <= 1'b1;
         end else if (ovf_clr) begin
            rx_overflow <= 1'b0;
         end else begin
            rx_overflow <= rx_overflow;
         end
      end
   end

   // TX FIFO pointers and occupancy.
   always_ff @(posedge clk_bus or posedge rst_bus) begin
      if (rst_bus) begin
         tx_wr_ptr <= {AW{1'b0}};
         tx_rd_ptr <= {AW{1'b0}};
         tx_count  <= CNT_ZERO;
      end else begin
         if (tx_push) tx_wr_ptr <= tx_wr_ptr + PTR_ONE;
         if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + PTR_ONE;
         case ({tx_push, tx_pop})
            2'b10:   tx_count <= tx_count + CNT_ONE;
            2'b01:   tx_count <= tx_count - CNT_ONE;
            default: tx_count <= tx_count;
         endcase
      end
   end

   // FIFO storage; contents need no reset since occupancy gates every read.
   always_ff @(posedge clk_bus) begin
      if (rx_push) rx_mem[rx_wr_ptr] <= rx_data;
      if (tx_push) tx_mem[tx_wr_ptr] <= bus.dat_i[7:0];
   end

   // Sequencer state, start pulse and held transmit byte.
   always_ff @(posedge clk_bus or posedge rst_bus) begin
      if (rst_bus) begin
         tx_state <= TX_IDLE;
         tx_start <= 1'b0;
         tx_data  <= 8'd0;
      end else begin
         tx_state <= tx_state_next;
         tx_start <= tx_pop;
         if (tx_pop) begin
            tx_data <= tx_mem[tx_rd_ptr];
         end else begin
            tx_data <= tx_data;
         end
      end
   end

endmodule

// File: tb/tb_uart_wb_slave.sv
// Randomised bench for uart_wb_slave against a queue-based model of the
// register map, FIFOs and transmit ordering.
module tb_uart_wb_slave;
   localparam int DEPTH = 16;

   logic       clk_bus = 1'b0;
   logic       rst_bus = 1'b0;
   logic [7:0] rx_data;
   logic       rx_ready;
   logic [7:0] tx_data;
   logic       tx_start;
   logic       tx_busy;

   uart_wb_slave_if bus ();

   uart_wb_slave #(.FIFO_DEPTH(DEPTH)) dut (
      .clk_bus  (clk_bus),
      .rst_bus  (rst_bus),
      .bus      (bus),
      .rx_data  (rx_data),
      .rx_ready (rx_ready),
      .tx_data  (tx_data),
      .tx_start (tx_start),
      .tx_busy  (tx_busy)
   );

   always #5 clk_bus = ~clk_bus;

   int         n_cmp = 0;
   int         n_bad = 0;
   int         n_starts = 0;
   time        last_start = 0;
   logic [7:0] rxq [$];
   logic [7:0] tx_pend [$];
   logic       ovf = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Every start pulse must carry the oldest accepted byte, at least 3 cycles apart.
   always @(posedge clk_bus) begin
      if (!rst_bus && tx_start === 1'b1) begin
         logic [31:0] e;
         if (n_starts > 0) check_eq("start_gap", 32'((($time - last_start) >= 30) ? 1 : 0), 32'd1);
         last_start = $time;
         n_starts++;
         e = (tx_pend.size() > 0) ? {24'd0, tx_pend.pop_front()} : 32'h100;
         check_eq("tx_byte", {24'd0, tx_data}, e);
      end
   end

   function automatic logic [31:0] model_status();
      return {28'd0, (tx_pend.size() == 0) && !tx_busy, ovf,
              tx_pend.size() < DEPTH, rxq.size() > 0};
   endfunction

   task automatic model_rx(input logic [7:0] b);
      if (rxq.size() < DEPTH) rxq.push_back(b);
      else ovf = 1'b1;
   endtask

   task automatic bus_op(input string name, input logic we, input logic [31:0] adr,
                         input logic [31:0] wdat, input logic [3:0] sel,
                         input logic also_rx, input logic [7:0] rxb);
      logic e_ack, e_err, e_rty;
      logic [31:0] e_dat;
      e_ack = 1'b0; e_err = 1'b0; e_rty = 1'b0; e_dat = 32'd0;
      if (adr[3]) begin
         e_err = 1'b1;
      end else if (!we) begin
         e_ack = 1'b1;
         if (adr[2]) e_dat = model_status();
         else if (rxq.size() > 0) e_dat = {24'd0, rxq.pop_front()};
      end else if (!adr[2]) begin
         if (!sel[0]) e_ack = 1'b1;
         else if (tx_pend.size() >= DEPTH) e_rty = 1'b1;
         else begin
            e_ack = 1'b1;
            tx_pend.push_back(wdat[7:0]);
         end
      end else begin
         e_ack = 1'b1;
         if (sel[0] && wdat[2]) ovf = 1'b0;
      end
      if (also_rx) model_rx(rxb);
      @(negedge clk_bus);
      bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = we;
      bus.adr_i = adr; bus.dat_i = wdat; bus.sel_i = sel;
      rx_ready = also_rx; rx_data = rxb;
      @(posedge clk_bus);
      #1;
      bus.cyc_i = 1'b0; bus.stb_i = 1'b0; rx_ready = 1'b0;
      check_eq({name, ".ack"}, {31'd0, bus.ack_o}, {31'd0, e_ack});
      check_eq({name, ".err"}, {31'd0, bus.err_o}, {31'd0, e_err});
      check_eq({name, ".rty"}, {31'd0, bus.rty_o}, {31'd0, e_rty});
      if (!we || adr[3]) check_eq({name, ".dat"}, bus.dat_o, e_dat);
   endtask

   task automatic rd(input string name, input logic [31:0] adr);
      bus_op(name, 1'b0, adr, 32'd0, 4'hF, 1'b0, 8'd0);
   endtask

   task automatic wr(input string name, input logic [31:0] adr, input logic [31:0] d);
      bus_op(name, 1'b1, adr, d, 4'hF, 1'b0, 8'd0);
   endtask

   task automatic rx_pulse(input logic [7:0] b);
      model_rx(b);
      @(negedge clk_bus);
      rx_ready = 1'b1; rx_data = b;
      @(posedge clk_bus);
      #1 rx_ready = 1'b0;
   endtask

   task automatic drain();
      tx_busy = 1'b0;
      for (int k = 0; k < 40 * DEPTH && tx_pend.size() > 0; k++) @(posedge clk_bus);
      check_eq("drain_done", tx_pend.size(), 32'd0);
      repeat (4) @(posedge clk_bus);
      #1;
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic found;
      int   n0;
      bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.we_i = 1'b0;
      bus.adr_i = 32'd0; bus.dat_i = 32'd0; bus.sel_i = 4'h0;
      rx_ready = 1'b0; rx_data = 8'd0; tx_busy = 1'b0;
      #1 rst_bus = 1'b1;
      #2;
      check_eq("rst_ack", {31'd0, bus.ack_o}, 32'd0);
      check_eq("rst_term", {30'd0, bus.err_o, bus.rty_o}, 32'd0);
      check_eq("rst_dat", bus.dat_o, 32'd0);
      check_eq("rst_tx", {23'd0, tx_start, tx_data}, 32'd0);
      @(negedge clk_bus) rst_bus = 1'b0;
      rd("status_after_reset", 32'h4);

      // RX path
      rx_pulse(8'h41); rx_pulse(8'h42);
      rd("rx_status", 32'h4);
      rd("rx_data0", 32'h0); rd("rx_data1", 32'h0);
      rd("rx_status_empty", 32'h4);

      // TX path: start pulse shortly after ack, then blocked while busy
      wr("tx_55", 32'h0, 32'h55);
      found = 1'b0;
      for (int k = 0; k < 3 && !found; k++) begin
         @(posedge clk_bus); #1;
         if (tx_start) found = 1'b1;
      end
      check_eq("tx_start_seen", {31'd0, found}, 32'd1);
      check_eq("tx_data_55", {24'd0, tx_data}, 32'h55);
      tx_busy = 1'b1;
      wr("tx_66", 32'h0, 32'h66);
      n0 = n_starts;
      repeat (20) @(posedge clk_bus);
      #1 check_eq("no_start_busy", n_starts, n0);
      tx_busy = 1'b0;
      for (int k = 0; k < 10 && n_starts == n0; k++) @(posedge clk_bus);
      #1 check_eq("start_after_busy", n_starts, n0 + 1);
      check_eq("tx_data_66", {24'd0, tx_data}, 32'h66);
      repeat (4) @(posedge clk_bus);

      // TX full
      tx_busy = 1'b1;
      for (int i = 0; i < DEPTH + 1; i++) wr("tx_fill", 32'h0, 32'($urandom_range(0, 255)));
      rd("tx_full_status", 32'h4);
      drain();

      // RX overflow
      for (int i = 0; i < DEPTH + 1; i++) rx_pulse(8'(i + 8'h10));
      rd("ovf_status", 32'h4);
      for (int i = 0; i < DEPTH; i++) rd("ovf_data", 32'h0);
      bus_op("ovf_clear", 1'b1, 32'h4, 32'h4, 4'h1, 1'b0, 8'd0);
      rd("ovf_status_clr", 32'h4);

      // Boundaries: full RX push+pop, empty RX push+pop, unmapped
      for (int i = 0; i < DEPTH; i++) rx_pulse(8'(i + 8'h80));
      bus_op("full_pushpop", 1'b0, 32'h0, 32'd0, 4'hF, 1'b1, 8'hA5);
      rd("full_pushpop_status", 32'h4);
      for (int i = 0; i < DEPTH + 1; i++) rd("full_drain", 32'h0);
      bus_op("empty_pushpop", 1'b0, 32'h0, 32'd0, 4'hF, 1'b1, 8'h3C);
      rd("empty_pushpop_data", 32'h0);
      rd("unmapped_8", 32'h8);
      wr("unmapped_c", 32'hC, 32'h4);

      // Randomised traffic, transmitter held busy between drains
      tx_busy = 1'b1;
      for (int it = 0; it < 400; it++) begin
         int unsigned r;
         logic [31:0] ra;
         r  = $urandom_range(0, 9);
         ra = $urandom() & 32'hFFFF_FFF3;
         case (r)
            0, 1, 2: rx_pulse(8'($urandom_range(0, 255)));
            3: bus_op("rnd_rd_rx", 1'b0, ra, 32'd0, 4'hF, ($urandom_range(0, 3) == 0),
                      8'($urandom_range(0, 255)));
            4: bus_op("rnd_rd", 1'b0, ra, 32'd0, 4'hF, 1'b0, 8'd0);
            5: bus_op("rnd_status", 1'b0, ra | 32'h4, 32'd0, 4'hF, 1'b0, 8'd0);
            6, 7: bus_op("rnd_wr", 1'b1, ra, $urandom(), 4'($urandom_range(0, 15)), 1'b0, 8'd0);
            8: bus_op("rnd_wr_status", 1'b1, ra | 32'h4, $urandom(), 4'($urandom_range(0, 15)),
                      ($urandom_range(0, 1) == 0), 8'($urandom_range(0, 255)));
            default: bus_op("rnd_unmapped", 1'($urandom_range(0, 1)), ra | 32'h8, $urandom(),
                            4'hF, 1'b0, 8'd0);
         endcase
         if (it % 80 == 79) begin
            drain();
            tx_busy = 1'b1;
            repeat (2) @(posedge clk_bus);
         end
      end

      // Reset during a pending termination with both FIFOs occupied
      drain();
      tx_busy = 1'b1;
      repeat (2) @(posedge clk_bus);
      rx_pulse(8'h11); rx_pulse(8'h22);
      wr("pre_rst_tx0", 32'h0, 32'h77);
      wr("pre_rst_tx1", 32'h0, 32'h88);
      @(negedge clk_bus);
      bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = 1'b0; bus.adr_i = 32'h4;
      @(posedge clk_bus);
      #1 bus.cyc_i = 1'b0; bus.stb_i = 1'b0;
      check_eq("pre_rst_ack", {31'd0, bus.ack_o}, 32'd1);
      #2 rst_bus = 1'b1;
      #1;
      check_eq("mid_rst_ack", {31'd0, bus.ack_o}, 32'd0);
      check_eq("mid_rst_dat", bus.dat_o, 32'd0);
      check_eq("mid_rst_tx", {23'd0, tx_start, tx_data}, 32'd0);
      rxq.delete(); tx_pend.delete(); ovf = 1'b0;
      @(negedge clk_bus) rst_bus = 1'b0;
      tx_busy = 1'b0;
      rd("post_rst_status", 32'h4);
      rd("post_rst_data", 32'h0);
      repeat (6) @(posedge clk_bus);
      #1 check_eq("post_rst_no_tx", {31'd0, tx_start}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
